// File: rtl/median5_seq_ctrl_if.sv
// Sample-in / median-out handshake bundle for the median-of-5 engine.
// The master side feeds samples, issues the synchronous abort and consumes
// results; the slave side is the engine itself.
interface median5_seq_ctrl_if #(
   parameter int W = 8
);
   logic         clr;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_median;
   logic         busy;

   modport master (
      output clr,
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_median,
      input  busy
   );

   modport slave (
      input  clr,
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_median,
      output busy
   );
endinterface

// File: rtl/median5_seq_ctrl.sv
// Sequential median-of-5 engine. Five samples are collected into a small
// register file, a single compare-exchange unit is stepped through a fixed
// 9-step partial bubble sort, and x[2] is then presented as the median.
// All outputs are registered or decoded from the state register only.
module median5_seq_ctrl #(
   parameter int W = 8
) (
   input logic               clk,
   input logic               rst_n,
   median5_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      SORT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [2:0]   cnt_q, cnt_d;
   logic [3:0]   step_q, step_d;
   logic [W-1:0] x_q [5];
   logic [W-1:0] x_d [5];
   logic [W-1:0] median_q, median_d;

   logic [2:0]   lo_idx;
   logic [W-1:0] cmp_a;
   logic [W-1:0] cmp_b;
   logic         do_swap;

   // Lower index of the pair handled at each sort step; passes shrink by one
   // pair each time because the largest remaining value has already bubbled up.
   always_comb begin
      lo_idx = 3'd0;
      case (step_q)
         4'd0:    lo_idx = 3'd0;
         4'd1:    lo_idx = 3'd1;
         4'd2:    lo_idx = 3'd2;
         4'd3:    lo_idx = 3'd3;
         4'd4:    lo_idx = 3'd0;
         4'd5:    lo_idx = 3'd1;
         4'd6:    lo_idx = 3'd2;
         4'd7:    lo_idx = 3'd0;
         4'd8:    lo_idx = 3'd1;
         default: lo_idx = 3'd0;
      endcase
   end

   // The one shared comparator: strict unsigned greater-than, so ties never swap.
   always_comb begin
      cmp_a   = x_q[lo_idx];
      cmp_b   = x_q[lo_idx + 3'd1];
      do_swap = (cmp_a > cmp_b);
   end

   // Next-state, sample capture, compare-exchange and result latch; clr overrides all.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      step_d   = step_q;
      median_d = median_q;
      for (int i = 0; i < 5; i++) begin
         x_d[i] = x_q[i];
      end

      case (state_q)
         LOAD: begin
            if (bus.in_valid) begin
               x_d[cnt_q] = bus.in_data;
               if (cnt_q == 3'd4) begin
                  cnt_d   = 3'd0;
                  step_d  = 4'd0;
                  state_d = SORT;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         SORT: begin
            if (do_swap) begin
               x_d[lo_idx]        = cmp_b;
               x_d[lo_idx + 3'd1] = cmp_a;
            end
            if (step_q == 4'd8) begin
               median_d = x_d[2];
               step_d   = 4'd0;
               state_d  = DONE;
            end else begin
               step_d = step_q + 4'd1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = LOAD;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase

      if (bus.clr) begin
         state_d  = LOAD;
         cnt_d    = 3'd0;
         step_d   = 4'd0;
         median_d = median_q;
         for (int i = 0; i < 5; i++) begin
            x_d[i] = x_q[i];
         end
      end
   end

   // State, counters, register file and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= LOAD;
         cnt_q    <= 3'd0;
         step_q   <= 4'd0;
         median_q <= '0;
         for (int i = 0; i < 5; i++) begin
            x_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         step_q   <= step_d;
         median_q <= median_d;
         for (int i = 0; i < 5; i++) begin
            x_q[i] <= x_d[i];
         end
      end
   end

   // Handshake flags and busy are pure state decodes, so no input reaches them combinationally.
   always_comb begin
      bus.in_ready   = (state_q == LOAD);
      bus.out_valid  = (state_q == DONE);
      bus.busy       = (state_q == SORT) || (state_q == DONE);
      bus.out_median = median_q;
   end

endmodule

// File: tb/tb_median5_seq_ctrl.sv
// Scoreboard bench for median5_seq_ctrl: the stimulus side pushes the
// expected median of every fifth accepted sample, and an independent monitor
// compares whatever the engine presents against the front of that queue.
module tb_median5_seq_ctrl;

   localparam int W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   median5_seq_ctrl_if #(.W(W)) bus ();

   median5_seq_ctrl #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int           vectors     = 0;
   int           miscompares = 0;
   logic [W-1:0] pending [$];
   logic [W-1:0] sb [$];
   logic [W-1:0] lastMedian;

   // Median by rank counting: the value with at most two smaller samples
   // and at least three samples not greater than it.
   function automatic logic [W-1:0] refMedian(input logic [W-1:0] s [$]);
      int less;
      int eq;
      foreach (s[i]) begin
         less = 0;
         eq   = 0;
         foreach (s[j]) begin
            if (s[j] < s[i]) less++;
            else if (s[j] == s[i]) eq++;
         end
         if (less <= 2 && (less + eq) >= 3) return s[i];
      end
      return '0;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Present one sample after an idle gap and hold it until the engine takes it.
   task automatic applyStimulus(input logic [W-1:0] v, input int gap);
      int guard;
      for (int i = 0; i < gap; i++) begin
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = v;
      guard = 0;
      while (!bus.in_ready && guard < 40) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (!bus.in_ready) begin
         checkOutput("in_ready timeout", 0, 1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      pending.push_back(v);
      if (pending.size() == 5) begin
         sb.push_back(refMedian(pending));
         pending.delete();
      end
   endtask

   // Called just after the fifth accept: engine must be busy and out_valid must rise 9 edges later.
   task automatic waitValid();
      int n;
      checkOutput("in_ready after 5th accept", int'(bus.in_ready), 0);
      checkOutput("busy during sort", int'(bus.busy), 1);
      n = 0;
      while (!bus.out_valid && n < 30) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("sort latency", n, 9);
   endtask

   // Hold off the result for a while (with ignored input pulses), then take it.
   task automatic drainResult(input int hold);
      for (int k = 0; k < hold; k++) begin
         bus.in_valid = k[0];
         bus.in_data  = W'($urandom_range(0, 255));
         @(posedge clk);
         #1;
         checkOutput("in_ready held low in DONE", int'(bus.in_ready), 0);
         checkOutput("out_valid held in DONE", int'(bus.out_valid), 1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checkOutput("out_valid after handshake", int'(bus.out_valid), 0);
      checkOutput("in_ready after handshake", int'(bus.in_ready), 1);
   endtask

   task automatic runMedian(input logic [W-1:0] v [5], input int g [5], input int hold);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(v[i], g[i]);
      end
      waitValid();
      drainResult(hold);
   endtask

   // Monitor: every cycle the engine shows a result it must match the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected out_valid", 1, 0);
            end else begin
               checkOutput("out_median", int'(bus.out_median), int'(sb[0]));
               if (bus.out_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [W-1:0] v [5];
      int           g [5];

      bus.clr       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      // Reset state
      #1;
      checkOutput("reset in_ready", int'(bus.in_ready), 1);
      checkOutput("reset out_valid", int'(bus.out_valid), 0);
      checkOutput("reset busy", int'(bus.busy), 0);
      checkOutput("reset out_median", int'(bus.out_median), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic median and ties/extremes
      g = '{0, 0, 0, 0, 0};
      v = '{8'd10, 8'd50, 8'd30, 8'd20, 8'd40};   runMedian(v, g, 0);
      v = '{8'd7, 8'd7, 8'd7, 8'd3, 8'd9};        runMedian(v, g, 0);
      v = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd128};  runMedian(v, g, 0);
      v = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};        runMedian(v, g, 0);
      v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};        runMedian(v, g, 0);
      v = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1};        runMedian(v, g, 0);

      // Backpressure, then a fresh set
      v = '{8'd100, 8'd200, 8'd150, 8'd50, 8'd25}; runMedian(v, g, 6);
      v = '{8'd9, 8'd1, 8'd8, 8'd2, 8'd5};         runMedian(v, g, 0);

      // Input gaps
      v = '{8'd40, 8'd10, 8'd30, 8'd20, 8'd50};
      g = '{0, 3, 0, 1, 0};
      runMedian(v, g, 0);
      g = '{0, 0, 0, 0, 0};

      // Asynchronous reset in the middle of the sort
      v = '{8'd200, 8'd201, 8'd202, 8'd203, 8'd204};
      for (int i = 0; i < 5; i++) applyStimulus(v[i], 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
      end
      #2;
      rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      pending.delete();
      checkOutput("mid-sort reset in_ready", int'(bus.in_ready), 1);
      checkOutput("mid-sort reset out_valid", int'(bus.out_valid), 0);
      checkOutput("mid-sort reset busy", int'(bus.busy), 0);
      checkOutput("mid-sort reset out_median", int'(bus.out_median), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      v = '{8'd3, 8'd1, 8'd2, 8'd5, 8'd4};
      runMedian(v, g, 0);

      // clr after three samples, with a sample offered in the same cycle
      applyStimulus(8'd11, 0);
      applyStimulus(8'd22, 0);
      applyStimulus(8'd33, 0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'd99;
      bus.clr      = 1'b1;
      @(posedge clk);
      #1;
      bus.clr      = 1'b0;
      bus.in_valid = 1'b0;
      pending.delete();
      checkOutput("in_ready after clr in LOAD", int'(bus.in_ready), 1);
      checkOutput("busy after clr in LOAD", int'(bus.busy), 0);
      v = '{8'd6, 8'd2, 8'd9, 8'd4, 8'd1};
      runMedian(v, g, 0);

      // clr while a result is waiting
      v = '{8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
      for (int i = 0; i < 5; i++) applyStimulus(v[i], 0);
      waitValid();
      bus.clr = 1'b1;
      @(posedge clk);
      #1;
      bus.clr = 1'b0;
      lastMedian = sb.pop_front();
      checkOutput("out_valid after clr in DONE", int'(bus.out_valid), 0);
      checkOutput("out_median kept after clr", int'(bus.out_median), int'(lastMedian));
      checkOutput("in_ready after clr in DONE", int'(bus.in_ready), 1);

      // Randomized sets, some with a narrow value range to force ties
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < 5; i++) begin
            v[i] = W'($urandom_range(0, 255));
            if (r[0]) v[i] = v[i] & 8'h07;
            g[i] = $urandom_range(0, 2);
         end
         runMedian(v, g, $urandom_range(0, 3));
      end

      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("scoreboard drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
